// File: rtl/param_bound_flasher.sv
// Thermometer LED flasher: a single up/down count walks a fixed sequence of ramps
// between parameterised bounds, with flick-driven kickbacks at the lower turning points.
//
// state | meaning
// IDLE  | waiting for flick, cnt held at 0
// UP1   | ramp up to N
// DN1   | ramp down to B1 (kickback point)
// UP2   | ramp up to B2
// DN2   | ramp down to 0
// UP3   | ramp up to N
// DN3   | ramp down to 0, then loop or finish
module param_bound_flasher #(
   parameter int N  = 16,
   parameter int B1 = 5,
   parameter int B2 = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flick,
   input  logic         loop,
   output logic [N-1:0] LED,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   localparam logic [CW-1:0] C_ZERO = '0;
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_N    = CW'(N);
   localparam logic [CW-1:0] C_NM1  = CW'(N - 1);
   localparam logic [CW-1:0] C_B1   = CW'(B1);
   localparam logic [CW-1:0] C_B1P1 = CW'(B1 + 1);
   localparam logic [CW-1:0] C_B2   = CW'(B2);
   localparam logic [CW-1:0] C_B2M1 = CW'(B2 - 1);

   if (!(B1 > 0 && B1 < B2 && B2 < N)) begin : g_bad_params
      $error("param_bound_flasher: requires 0 < B1 < B2 < N");
   end

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP1  = 3'd1,
      DN1  = 3'd2,
      UP2  = 3'd3,
      DN2  = 3'd4,
      UP3  = 3'd5,
      DN3  = 3'd6
   } phase_t;

   phase_t        phase, phase_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          done_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         phase <= phase_nx;
         cnt   <= cnt_nx;
         busy  <= (phase_nx != IDLE);
         done  <= done_nx;
      end
   end

   // Turning points step in the new direction on the same edge (no dwell).
   always_comb begin
      phase_nx = phase;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      case (phase)
         IDLE: begin
            cnt_nx = C_ZERO;
            if (flick) begin
               phase_nx = UP1;
               cnt_nx   = C_ONE;
            end
         end
         UP1: begin
            if (cnt == C_N) begin
               phase_nx = DN1;
               cnt_nx   = C_NM1;
            end else begin
               cnt_nx = cnt + C_ONE;
            end
         end
         DN1: begin
            if (cnt == C_B1) begin
               phase_nx = flick ? UP1 : UP2;
               cnt_nx   = C_B1P1;
            end else begin
               cnt_nx = cnt - C_ONE;
            end
         end
         UP2: begin
            if (cnt == C_B2) begin
               phase_nx = DN2;
               cnt_nx   = C_B2M1;
            end else begin
               cnt_nx = cnt + C_ONE;
            end
         end
         DN2: begin
            if (cnt == C_B1 && flick) begin
               phase_nx = UP2;
               cnt_nx   = C_B1P1;
            end else if (cnt == C_ZERO) begin
               phase_nx = flick ? UP2 : UP3;
               cnt_nx   = C_ONE;
            end else begin
               cnt_nx = cnt - C_ONE;
            end
         end
         UP3: begin
            if (cnt == C_N) begin
               phase_nx = DN3;
               cnt_nx   = C_NM1;
            end else begin
               cnt_nx = cnt + C_ONE;
            end
         end
         DN3: begin
            if (cnt == C_B1 && flick) begin
               phase_nx = UP3;
               cnt_nx   = C_B1P1;
            end else if (cnt == C_ZERO) begin
               if (flick) begin
                  phase_nx = UP3;
                  cnt_nx   = C_ONE;
               end else if (loop) begin
                  phase_nx = UP1;
                  cnt_nx   = C_ONE;
               end else begin
                  phase_nx = IDLE;
                  cnt_nx   = C_ZERO;
                  done_nx  = 1'b1;
               end
            end else begin
               cnt_nx = cnt - C_ONE;
            end
         end
         default: begin
            phase_nx = IDLE;
            cnt_nx   = C_ZERO;
         end
      endcase
   end

   for (genvar i = 0; i < N; i++) begin : g_led
      assign LED[i] = (cnt > CW'(i));
   end

endmodule

// File: tb/tb_param_bound_flasher.sv
// Bench for param_bound_flasher: default and reduced-parameter instances, directed
// stimulus pushes expected per-edge state into queues, a monitor pops and compares.
module tb_param_bound_flasher;

   logic        clk;
   logic        rst_n;
   logic        flick_a, flick_b, loop;
   logic [15:0] led_a;
   logic [7:0]  led_b;
   logic        busy_a, done_a, busy_b, done_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int c;
      bit b;
      bit d;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   param_bound_flasher dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .flick (flick_a),
      .loop  (loop),
      .LED   (led_a),
      .busy  (busy_a),
      .done  (done_a)
   );

   param_bound_flasher #(.N(8), .B1(2), .B2(5)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .flick (flick_b),
      .loop  (loop),
      .LED   (led_b),
      .busy  (busy_b),
      .done  (done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: one expected entry per rising edge, sampled just after it.
   initial begin
      exp_t e;
      logic [15:0] el_a;
      logic [7:0]  el_b;
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            el_a = 16'((32'd1 << e.c) - 32'd1);
            chk("a_led", 32'(led_a), 32'(el_a));
            chk("a_busy", 32'(busy_a), 32'(e.b));
            chk("a_done", 32'(done_a), 32'(e.d));
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            el_b = 8'((32'd1 << e.c) - 32'd1);
            chk("b_led", 32'(led_b), 32'(el_b));
            chk("b_busy", 32'(busy_b), 32'(e.b));
            chk("b_done", 32'(done_b), 32'(e.d));
         end
      end
   end

   task automatic cyc(input bit sel, input bit f, input bit l, input int c, input bit b, input bit d);
      exp_t e;
      @(negedge clk);
      e.c = c;
      e.b = b;
      e.d = d;
      loop = l;
      if (sel) begin
         flick_b = f;
         q_b.push_back(e);
      end else begin
         flick_a = f;
         q_a.push_back(e);
      end
   endtask

   task automatic up(input bit sel, input int lo, input int hi);
      for (int v = lo; v <= hi; v++) cyc(sel, 1'b0, 1'b0, v, 1'b1, 1'b0);
   endtask

   task automatic dn(input bit sel, input int hi, input int lo);
      for (int v = hi; v >= lo; v--) cyc(sel, 1'b0, 1'b0, v, 1'b1, 1'b0);
   endtask

   task automatic fin(input bit sel);
      cyc(sel, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      cyc(sel, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic full_a();
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 5);
      up(1'b0, 6, 10);
      dn(1'b0, 9, 0);
      up(1'b0, 1, 16);
      dn(1'b0, 15, 0);
      fin(1'b0);
   endtask

   initial begin
      rst_n   = 1'b0;
      flick_a = 1'b1;
      flick_b = 1'b1;
      loop    = 1'b0;
      #3;
      chk("rst_led_imm", 32'(led_a), 32'h0);
      chk("rst_busy_imm", 32'(busy_a), 32'h0);

      // Flicks while in reset are ignored
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      flick_a = 1'b0;
      flick_b = 1'b0;
      q_a.push_back('{0, 1'b0, 1'b0});
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Plain sequence, defaults
      full_a();

      // Kickbacks at DN1 cnt==B1 and DN2 cnt==0
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 5);
      cyc(1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
      up(1'b0, 7, 16);
      dn(1'b0, 15, 5);
      up(1'b0, 6, 10);
      dn(1'b0, 9, 0);
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 10);
      dn(1'b0, 9, 0);
      up(1'b0, 1, 16);
      dn(1'b0, 15, 0);
      fin(1'b0);

      // Flick held in UP2, DN2 kick at B1, DN3 held flick, DN3 kick at 0, loop restart
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 5);
      up(1'b0, 6, 6);
      cyc(1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 9, 1'b1, 1'b0);
      up(1'b0, 10, 10);
      dn(1'b0, 9, 5);
      cyc(1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
      up(1'b0, 7, 10);
      dn(1'b0, 9, 0);
      up(1'b0, 1, 16);
      dn(1'b0, 15, 5);
      cyc(1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
      up(1'b0, 9, 16);
      dn(1'b0, 15, 0);
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 0);
      cyc(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 5);
      up(1'b0, 6, 10);
      dn(1'b0, 9, 0);
      up(1'b0, 1, 16);
      dn(1'b0, 15, 0);
      fin(1'b0);

      // Asynchronous reset mid-DN2 at cnt=7
      cyc(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b0, 2, 16);
      dn(1'b0, 15, 5);
      up(1'b0, 6, 10);
      dn(1'b0, 9, 7);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_led", 32'(led_a), 32'h0);
      chk("midrst_busy", 32'(busy_a), 32'h0);
      chk("midrst_done", 32'(done_a), 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      flick_a = 1'b0;
      q_a.push_back('{0, 1'b0, 1'b0});
      full_a();

      // Reduced parameters N=8, B1=2, B2=5: 39 edges to done
      cyc(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      up(1'b1, 2, 8);
      dn(1'b1, 7, 2);
      up(1'b1, 3, 5);
      dn(1'b1, 4, 0);
      up(1'b1, 1, 8);
      dn(1'b1, 7, 0);
      fin(1'b1);

      @(posedge clk);
      #3;
      chk("queue_a_drained", 32'(q_a.size()), 32'h0);
      chk("queue_b_drained", 32'(q_b.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
